// File: rtl/iter_muldiv.sv
// Iterative HI/LO multiply/divide unit: fixed-latency multiply/accumulate and a
// restoring radix-2 divider, with direct HI/LO writes, flush and done pulse.
module iter_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = 7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [1:0]         mode_reg, mode_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   dvsr_reg, dvsr_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               bzero_reg, bzero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;
  logic               dbz_reg, dbz_next;

  // Operand conditioning at acceptance
  logic               is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;

  always_comb begin
    is_signed = ~op[0];
    is_div    = (op[2:1] == 2'b01);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    a_ext     = {{WIDTH{a_neg}}, a};
    b_ext     = {{WIDTH{b_neg}}, b};
    product   = a_ext * b_ext;
  end

  // Accumulate step and divider step, both working on registered state
  logic [2*WIDTH-1:0] acc, mul_result;
  logic [WIDTH:0]     rem_shift;
  logic               can_sub;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    acc = {hi_reg, lo_reg};
    case (mode_reg)
      2'b10:   mul_result = acc + prod_reg;
      2'b11:   mul_result = acc - prod_reg;
      default: mul_result = prod_reg;
    endcase
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    can_sub   = (rem_shift >= {1'b0, dvsr_reg});
    quo_fix   = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    rem_fix   = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= '0;
      a_reg     <= '0;
      prod_reg  <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      bzero_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      a_reg     <= a_next;
      prod_reg  <= prod_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dvsr_reg  <= dvsr_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      bzero_reg <= bzero_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    a_next     = a_reg;
    prod_next  = prod_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dvsr_next  = dvsr_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    bzero_next = bzero_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    dbz_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Direct writes and flush both block a start in the same cycle
        if (wr_hi || wr_lo) begin
          if (wr_hi) hi_next = wdata;
          if (wr_lo) lo_next = wdata;
        end else if (start && !flush) begin
          mode_next = op[2:1];
          a_next    = a;
          if (is_div) begin
            state_next = DIV;
            cnt_next   = CW'(WIDTH - 1);
            quo_next   = a_mag;
            rem_next   = '0;
            dvsr_next  = b_mag;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            bzero_next = (b == '0);
          end else begin
            state_next = MUL;
            cnt_next   = CW'(MUL_LAT - 1);
            prod_next  = product;
          end
        end
      end

      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          {hi_next, lo_next} = mul_result;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          quo_next = {quo_reg[WIDTH-2:0], can_sub};
          rem_next = can_sub ? (rem_shift[WIDTH-1:0] - dvsr_reg) : rem_shift[WIDTH-1:0];
          if (cnt_reg == '0) state_next = FIX;
          else               cnt_next   = cnt_reg - 1'b1;
        end
      end

      FIX: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (bzero_reg) begin
            lo_next  = '1;
            hi_next  = a_reg;
            dbz_next = 1'b1;
          end else begin
            lo_next = quo_fix;
            hi_next = rem_fix;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: a cycle-level arithmetic model checked every
// cycle, plus hand-computed literal results for each directed transaction.
module tb_iter_muldiv;
  localparam int W  = 32;
  localparam int ML = 5;

  logic         clk = 1'b0;
  logic         reset, start, flush, wr_hi, wr_lo;
  logic [2:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  iter_muldiv #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic         m_done = 1'b0, m_dbz = 1'b0;
  logic [2:0]   m_op = '0;

  function automatic logic [2*W-1:0] mul_ref(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sp;
    if (!o[0]) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      return sp;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic model_commit;
    logic [2*W-1:0] p, acc;
    m_done = 1'b1;
    if (m_op == 3'd2 || m_op == 3'd3) begin
      m_dbz = (m_b == '0);
      if (m_b == '0) begin
        m_lo = '1;
        m_hi = m_a;
      end else if (m_op == 3'd2 && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
        m_lo = m_a;
        m_hi = '0;
      end else if (m_op == 3'd2) begin
        m_lo = $signed(m_a) / $signed(m_b);
        m_hi = $signed(m_a) % $signed(m_b);
      end else begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
    end else begin
      p   = mul_ref(m_op, m_a, m_b);
      acc = {m_hi, m_lo};
      if (m_op < 3'd2)      {m_hi, m_lo} = p;
      else if (m_op < 3'd6) {m_hi, m_lo} = acc + p;
      else                  {m_hi, m_lo} = acc - p;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
      end else begin
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (m_left > 0) begin
          if (flush) m_left = 0;
          else begin
            m_left--;
            if (m_left == 0) model_commit();
          end
        end else if (wr_hi || wr_lo) begin
          if (wr_hi) m_hi = wdata;
          if (wr_lo) m_lo = wdata;
        end else if (start && !flush) begin
          m_op = op; m_a = a; m_b = b;
          m_left = (op == 3'd2 || op == 3'd3) ? W + 1 : ML;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
        chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic dz);
    lat = 0;
    dz  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        dz = div_by_zero;
        $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d dbz=%0b", op, a, b, hi, lo, lat, dz);
        return;
      end
      if (busy) lat++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done expected done within 200 cycles");
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic dz);
    issue(o, x, y);
    wait_done(lat, dz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int   lat;
  logic dz;
  bit   seen;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, dz);
    chk("mult_lat", 64'(lat), 64'd5);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    do_op(3'd3, 32'd100, 32'd7, lat, dz);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, dz);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    do_op(3'd3, 32'd5, 32'd0, lat, dz);
    chk("dbz_flag", 64'(dz), 64'h1);
    chk("dbz_lat", 64'(lat), 64'd33);
    chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dbz_hi", 64'(hi), 64'd5);

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, dz);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'h0);
    chk("ovf_dbz", 64'(dz), 64'h0);

    // HI/LO direct writes, then accumulate
    @(posedge clk); #1 wr_hi = 1'b1; wr_lo = 1'b1; wdata = '0;
    @(posedge clk); #1 wr_hi = 1'b0; wdata = 32'd10;
    @(posedge clk); #1 wr_lo = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", 64'(lo), 64'd10);
    chk("mthi_hi", 64'(hi), 64'd0);
    do_op(3'd5, 32'd3, 32'd4, lat, dz);
    chk("maddu_hi", 64'(hi), 64'd0);
    chk("maddu_lo", 64'(lo), 64'd22);
    do_op(3'd6, 32'd1, 32'd23, lat, dz);
    chk("msub_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("msub_lo", 64'(lo), 64'hFFFF_FFFF);

    // Flush during divide cycle 10
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("flush_lo", 64'(lo), 64'hFFFF_FFFF);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("flush_no_done", 64'(seen), 64'h0);
    $display("txn flush of DIVU 1000/3 at cycle 10");

    // Reset during multiply cycle 2
    issue(3'd0, 32'd2, 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("rst_no_done", 64'(seen), 64'h0);
    $display("txn reset during MULT 2*3");

    // start + wr_lo while busy are ignored; one busy cycle already elapsed here
    issue(3'd1, 32'd2, 32'd3);
    start = 1'b1; op = 3'd3; wr_lo = 1'b1; wdata = 32'd55;
    @(posedge clk); #1 start = 1'b0; wr_lo = 1'b0; op = 3'd1;
    wait_done(lat, dz);
    chk("ign_lat", 64'(lat), 64'd4);
    chk("ign_lo", 64'(lo), 64'd6);
    chk("ign_hi", 64'(hi), 64'd0);

    // Start issued in the done cycle
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'h1);
    wait_done(lat, dz);
    chk("b2b_lat", 64'(lat), 64'd4);
    chk("b2b_lo", 64'(lo), 64'd4);
    chk("b2b_hi", 64'(hi), 64'd0);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (legal values: 8 to 64, even).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply-class busy cycles (legal values: 1 to 15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new operation (valid only when idle).
REQ-006 SHALL have port op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-007 SHALL have port a, b  input  WIDTH  source operands (rs, rt); sampled only on an accepted start.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port wr_hi, wr_lo  input  1  direct HI/LO write strobes (MTHI/MTLO).
REQ-010 SHALL have port wdata  input  WIDTH  data for wr_hi/wr_lo.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking a result commit.
REQ-013 SHALL have port div_by_zero  output  1  asserted with done when the divisor was 0.
REQ-014 SHALL have port hi, lo  output  WIDTH  registered HI/LO contents.

Function
REQ-015 SHALL use a FSM with states IDLE, MUL, DIV, FIX; busy=1 in every state except IDLE.
REQ-016 SHALL accept start only in IDLE with wr_hi=wr_lo=flush=0; start in any other case is ignored.
REQ-017 SHALL capture a, b and op at the accepting edge.
REQ-018 Multiply class (op 0,1,4,5,6,7) SHALL form the 2*WIDTH product at acceptance, signed for even op, unsigned for odd op, then hold it in MUL for exactly MUL_LAT cycles.
REQ-019 At the MUL exit edge, {hi,lo} SHALL become product (MULT/MULTU), {hi,lo}+product (MADD/MADDU) or {hi,lo}-product (MSUB/MSUBU), modulo 2^(2*WIDTH), using the HI/LO values current at that edge.
REQ-020 Divide class SHALL use a restoring shift-subtract divider on operand magnitudes (signed ops: absolute values), one quotient bit per cycle, for WIDTH cycles in DIV.
REQ-021 FIX SHALL last 1 cycle, apply signs (quotient negative iff operand signs differ, remainder takes the sign of a), and commit lo=quotient, hi=remainder; total divide busy time = WIDTH+1 cycles.
REQ-022 Signed overflow (a=most-negative, b=-1) SHALL yield lo=a, hi=0.
REQ-023 b=0 for DIV/DIVU SHALL still take the full latency, commit lo=all-ones, hi=a, and assert div_by_zero together with done.
REQ-024 done SHALL be registered, high for exactly the one cycle in which the new hi/lo first appear; busy SHALL be 0 in that same cycle, so a new start SHALL be accepted in it.
REQ-025 flush while busy SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and no done.
REQ-026 flush while IDLE SHALL have no effect.
REQ-027 wr_hi/wr_lo in IDLE SHALL load wdata into hi/lo at the next edge; both strobes together load both registers.
REQ-028 wr_hi/wr_lo while busy SHALL be ignored.
REQ-029 div_by_zero SHALL be 0 whenever done is 0.

Reset
REQ-030 reset SHALL take priority over every other input, force IDLE, and clear hi, lo, busy, done and div_by_zero to 0 at the next edge, including mid-operation (no commit).

Verification
REQ-031 MULT a=-3, b=5 (WIDTH=32, MUL_LAT=5) -> busy 5 cycles, then done with hi=FFFFFFFF, lo=FFFFFFF1.
REQ-032 DIVU a=100, b=7 -> busy 33 cycles, then done with lo=14, hi=2; DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 DIVU a=5, b=0 -> done and div_by_zero together, lo=FFFFFFFF, hi=5; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-034 wr_hi=1, wr_lo=1 with wdata=0, then wr_lo=1 with wdata=10, then MADDU a=3, b=4 -> hi=0, lo=22; MSUB a=1, b=23 -> hi=FFFFFFFF, lo=FFFFFFFF.
REQ-035 flush at DIV cycle 10 -> busy 0 next cycle, no done, hi/lo unchanged; reset at MUL cycle 2 -> all outputs 0, no commit.
REQ-036 start plus wr_lo while busy -> both ignored; start issued in the done cycle -> accepted, busy=1 the next cycle.
